// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing one L2 AXI port among the L1 slots (CPU I/D caches, uncached/DMA).
// One transaction in flight at a time; snoop channels toward the L1s are tied inactive.

package l1_l2_arbiter_pkg;

    localparam int unsigned CFG_SLOT_L1_TOTAL      = 3;
    localparam int unsigned CFG_SLOT_L1_LOG2       = 2;
    localparam int unsigned CFG_ADDR_BITS          = 32;
    localparam int unsigned CFG_ID_BITS            = 4;
    localparam int unsigned CFG_USER_BITS          = 2;
    localparam int unsigned L1CACHE_LINE_BITS      = 64;
    localparam int unsigned L1CACHE_BYTES_PER_LINE = L1CACHE_LINE_BITS / 8;
    localparam int unsigned L2CACHE_LINE_BITS      = 64;
    localparam int unsigned L2CACHE_BYTES_PER_LINE = 8;

    typedef struct packed {
        logic [CFG_ADDR_BITS-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
        logic                     lock;
        logic [3:0]               cache;
        logic [2:0]               prot;
        logic [3:0]               qos;
        logic [3:0]               region;
    } axi4_metadata_type;

    localparam axi4_metadata_type META_NONE = '0;

    // L1 -> arbiter
    typedef struct packed {
        logic                              aw_valid;
        axi4_metadata_type                 aw_bits;
        logic [CFG_ID_BITS-1:0]            aw_id;
        logic [CFG_USER_BITS-1:0]          aw_user;
        logic                              w_valid;
        logic [L1CACHE_LINE_BITS-1:0]      w_data;
        logic                              w_last;
        logic [L1CACHE_BYTES_PER_LINE-1:0] w_strb;
        logic [CFG_USER_BITS-1:0]          w_user;
        logic                              b_ready;
        logic                              ar_valid;
        axi4_metadata_type                 ar_bits;
        logic [CFG_ID_BITS-1:0]            ar_id;
        logic [CFG_USER_BITS-1:0]          ar_user;
        logic                              r_ready;
        logic                              ac_ready;
        logic                              cr_valid;
        logic [4:0]                        cr_resp;
        logic                              cd_valid;
        logic [L1CACHE_LINE_BITS-1:0]      cd_data;
        logic                              cd_last;
        logic                              rack;
        logic                              wack;
    } axi4_l1_out_type;

    // arbiter -> L1
    typedef struct packed {
        logic                         aw_ready;
        logic                         w_ready;
        logic                         b_valid;
        logic [1:0]                   b_resp;
        logic [CFG_ID_BITS-1:0]       b_id;
        logic [CFG_USER_BITS-1:0]     b_user;
        logic                         ar_ready;
        logic                         r_valid;
        logic [3:0]                   r_resp;
        logic [L1CACHE_LINE_BITS-1:0] r_data;
        logic                         r_last;
        logic [CFG_ID_BITS-1:0]       r_id;
        logic [CFG_USER_BITS-1:0]     r_user;
        logic                         ac_valid;
        logic [CFG_ADDR_BITS-1:0]     ac_addr;
        logic [3:0]                   ac_snoop;
        logic [2:0]                   ac_prot;
        logic                         cr_ready;
        logic                         cd_ready;
    } axi4_l1_in_type;

    // arbiter -> L2
    typedef struct packed {
        logic                              aw_valid;
        axi4_metadata_type                 aw_bits;
        logic [CFG_ID_BITS-1:0]            aw_id;
        logic [CFG_USER_BITS-1:0]          aw_user;
        logic                              w_valid;
        logic [L2CACHE_LINE_BITS-1:0]      w_data;
        logic                              w_last;
        logic [L2CACHE_BYTES_PER_LINE-1:0] w_strb;
        logic [CFG_USER_BITS-1:0]          w_user;
        logic                              b_ready;
        logic                              ar_valid;
        axi4_metadata_type                 ar_bits;
        logic [CFG_ID_BITS-1:0]            ar_id;
        logic [CFG_USER_BITS-1:0]          ar_user;
        logic                              r_ready;
    } axi4_l2_out_type;

    // L2 -> arbiter
    typedef struct packed {
        logic                         aw_ready;
        logic                         w_ready;
        logic                         b_valid;
        logic [1:0]                   b_resp;
        logic [CFG_ID_BITS-1:0]       b_id;
        logic [CFG_USER_BITS-1:0]     b_user;
        logic                         ar_ready;
        logic                         r_valid;
        logic [1:0]                   r_resp;
        logic [L2CACHE_LINE_BITS-1:0] r_data;
        logic                         r_last;
        logic [CFG_ID_BITS-1:0]       r_id;
        logic [CFG_USER_BITS-1:0]     r_user;
    } axi4_l2_in_type;

    typedef axi4_l1_out_type [CFG_SLOT_L1_TOTAL-1:0] axi4_l1_out_vector;
    typedef axi4_l1_in_type  [CFG_SLOT_L1_TOTAL-1:0] axi4_l1_in_vector;

    localparam axi4_l1_in_type  axi4_l1_in_none  = '0;
    localparam axi4_l2_out_type axi4_l2_out_none = '0;

endpackage

module l1_l2_arbiter
    import l1_l2_arbiter_pkg::*;
#(
    parameter bit prefer_read = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  axi4_l1_out_vector           i_l1o,
    output axi4_l1_in_vector            o_l1i,
    input  axi4_l2_in_type              i_l2i,
    output axi4_l2_out_type             o_l2o,
    output logic                        o_busy,
    output logic [CFG_SLOT_L1_LOG2-1:0] o_grant
);

    if ((L1CACHE_LINE_BITS != L2CACHE_LINE_BITS) ||
        (L1CACHE_BYTES_PER_LINE != L2CACHE_BYTES_PER_LINE)) begin : g_line_check
        $error("l1_l2_arbiter: L1 and L2 cache line geometry differ");
    end

    typedef enum logic [2:0] {StIdle, StReqAr, StWaitR, StReqAw, StReqW, StWaitB} state_e;

    state_e                      state_q, state_d;
    logic [CFG_SLOT_L1_LOG2-1:0] rr_q, rr_d;
    logic [CFG_SLOT_L1_LOG2-1:0] grant_q, grant_d;
    axi4_metadata_type           meta_q, meta_d;
    logic [CFG_USER_BITS-1:0]    user_q, user_d;

    logic [CFG_SLOT_L1_TOTAL-1:0] cand;
    logic                         found;
    logic [CFG_SLOT_L1_LOG2-1:0]  win;
    logic                         win_read;
    logic [CFG_ID_BITS-1:0]       grant_id;

    assign grant_id = {{(CFG_ID_BITS - CFG_SLOT_L1_LOG2){1'b0}}, grant_q};

    // No grant while reset is asserted, so an L1 never sees a ready that the FSM then forgets.
    always_comb begin : arb_search
        int unsigned                 idx;
        logic [CFG_SLOT_L1_LOG2-1:0] slot;
        cand  = '0;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        slot  = '0;
        for (int unsigned i = 0; i < CFG_SLOT_L1_TOTAL; i++) begin
            cand[i] = (i_l1o[i].ar_valid | i_l1o[i].aw_valid) & ~i_rst;
        end
        for (int unsigned k = 1; k <= CFG_SLOT_L1_TOTAL; k++) begin
            idx  = (32'(rr_q) + k) % CFG_SLOT_L1_TOTAL;
            slot = idx[CFG_SLOT_L1_LOG2-1:0];
            if (!found && cand[slot]) begin
                found = 1'b1;
                win   = slot;
            end
        end
    end

    always_comb begin : dir_select
        if (i_l1o[win].ar_valid && i_l1o[win].aw_valid) begin
            win_read = prefer_read;
        end else begin
            win_read = i_l1o[win].ar_valid;
        end
    end

    always_comb begin : fsm_comb
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        meta_d  = meta_q;
        user_d  = user_q;
        for (int unsigned i = 0; i < CFG_SLOT_L1_TOTAL; i++) begin
            o_l1i[i] = axi4_l1_in_none;
        end
        o_l2o = axi4_l2_out_none;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    rr_d    = win;
                    grant_d = win;
                    if (win_read) begin
                        o_l1i[win].ar_ready = 1'b1;
                        meta_d              = i_l1o[win].ar_bits;
                        user_d              = i_l1o[win].ar_user;
                        state_d             = StReqAr;
                    end else begin
                        o_l1i[win].aw_ready = 1'b1;
                        meta_d              = i_l1o[win].aw_bits;
                        user_d              = i_l1o[win].aw_user;
                        state_d             = StReqAw;
                    end
                end
            end
            StReqAr: begin
                o_l2o.ar_valid = 1'b1;
                o_l2o.ar_bits  = meta_q;
                o_l2o.ar_id    = grant_id;
                o_l2o.ar_user  = user_q;
                if (i_l2i.ar_ready) begin
                    state_d = StWaitR;
                end
            end
            StWaitR: begin
                o_l1i[grant_q].r_valid = i_l2i.r_valid;
                o_l1i[grant_q].r_data  = i_l2i.r_data;
                o_l1i[grant_q].r_last  = i_l2i.r_last;
                o_l1i[grant_q].r_id    = i_l2i.r_id;
                o_l1i[grant_q].r_user  = i_l2i.r_user;
                o_l1i[grant_q].r_resp  = {2'b00, i_l2i.r_resp};
                o_l2o.r_ready          = i_l1o[grant_q].r_ready;
                if (i_l2i.r_valid && i_l1o[grant_q].r_ready && i_l2i.r_last) begin
                    state_d = StIdle;
                end
            end
            StReqAw: begin
                o_l2o.aw_valid = 1'b1;
                o_l2o.aw_bits  = meta_q;
                o_l2o.aw_id    = grant_id;
                o_l2o.aw_user  = user_q;
                if (i_l2i.aw_ready) begin
                    state_d = StReqW;
                end
            end
            StReqW: begin
                o_l2o.w_valid          = i_l1o[grant_q].w_valid;
                o_l2o.w_data           = i_l1o[grant_q].w_data;
                o_l2o.w_strb           = i_l1o[grant_q].w_strb;
                o_l2o.w_last           = i_l1o[grant_q].w_last;
                o_l2o.w_user           = i_l1o[grant_q].w_user;
                o_l1i[grant_q].w_ready = i_l2i.w_ready;
                if (i_l1o[grant_q].w_valid && i_l2i.w_ready && i_l1o[grant_q].w_last) begin
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                o_l1i[grant_q].b_valid = i_l2i.b_valid;
                o_l1i[grant_q].b_resp  = i_l2i.b_resp;
                o_l1i[grant_q].b_id    = i_l2i.b_id;
                o_l1i[grant_q].b_user  = i_l2i.b_user;
                o_l2o.b_ready          = i_l1o[grant_q].b_ready;
                if (i_l2i.b_valid && i_l1o[grant_q].b_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            rr_q    <= '0;
            grant_q <= '0;
            meta_q  <= META_NONE;
            user_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            meta_q  <= meta_d;
            user_q  <= user_d;
        end
    end

    assign o_busy  = (state_q != StIdle);
    assign o_grant = grant_q;

    // Snoop responses, L1 ids and rack/wack are deliberately not consumed.
    logic unused_inputs;
    assign unused_inputs = ^{i_l1o, i_l2i};

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: reset, single read, write with W stall, round robin,
// reset mid-read, R backpressure and read/write priority on one slot.

module tb_l1_l2_arbiter;
    import l1_l2_arbiter_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    axi4_l1_out_vector           l1o;
    axi4_l1_in_vector            l1i;
    axi4_l2_in_type              l2i;
    axi4_l2_out_type             l2o;
    logic                        busy;
    logic [CFG_SLOT_L1_LOG2-1:0] grant;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    l1_l2_arbiter #(
        .prefer_read(1'b1)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_l1o  (l1o),
        .o_l1i  (l1i),
        .i_l2i  (l2i),
        .o_l2o  (l2o),
        .o_busy (busy),
        .o_grant(grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [2:0] ar_readys();
        return {l1i[2].ar_ready, l1i[1].ar_ready, l1i[0].ar_ready};
    endfunction

    int unsigned order [4] = '{1, 2, 0, 1};

    initial begin
        rst = 1'b1;
        l1o = '0;
        l2i = '0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_l1i_none", 64'(l1i === '0), 64'd1);
        chk("rst_l2o_none", 64'(l2o === '0), 64'd1);
        tick();
        chk("idle_no_req", 64'(busy), 64'd0);

        // single read, slot1
        l1o[1].ar_valid      = 1'b1;
        l1o[1].ar_bits.addr  = 32'h8000_0040;
        l1o[1].ar_bits.size  = 3'd3;
        l1o[1].ar_user       = 2'd2;
        settle();
        chk("rd_ar_ready", 64'(ar_readys()), 64'h2);
        chk("rd_slot0_none", 64'(l1i[0] === '0), 64'd1);
        tick();
        l1o[1].ar_valid = 1'b0;
        l1o[1].ar_bits  = '0;
        settle();
        chk("rd_busy", 64'(busy), 64'd1);
        chk("rd_grant", 64'(grant), 64'd1);
        chk("rd_l2_ar_valid", 64'(l2o.ar_valid), 64'd1);
        chk("rd_l2_ar_addr", 64'(l2o.ar_bits.addr), 64'h8000_0040);
        chk("rd_l2_ar_id", 64'(l2o.ar_id), 64'd1);
        chk("rd_l2_ar_user", 64'(l2o.ar_user), 64'd2);
        tick();
        chk("rd_ar_hold_valid", 64'(l2o.ar_valid), 64'd1);
        chk("rd_ar_hold_addr", 64'(l2o.ar_bits.addr), 64'h8000_0040);
        l2i.ar_ready = 1'b1;
        tick();
        l2i.ar_ready   = 1'b0;
        l2i.r_valid    = 1'b1;
        l2i.r_data     = 64'hA5A5_A5A5_A5A5_A5A5;
        l2i.r_last     = 1'b1;
        l2i.r_id       = 4'd1;
        l2i.r_resp     = 2'b11;
        l1o[1].r_ready = 1'b1;
        settle();
        chk("rd_r_valid", 64'(l1i[1].r_valid), 64'd1);
        chk("rd_r_data", l1i[1].r_data, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("rd_r_last", 64'(l1i[1].r_last), 64'd1);
        chk("rd_r_resp", 64'(l1i[1].r_resp), 64'h3);
        chk("rd_r_other", 64'({l1i[2].r_valid, l1i[0].r_valid}), 64'd0);
        chk("rd_l2_r_ready", 64'(l2o.r_ready), 64'd1);
        chk("rd_ar_ready_busy", 64'(ar_readys()), 64'd0);
        tick();
        l2i = '0;
        l1o[1].r_ready = 1'b0;
        settle();
        chk("rd_back_idle", 64'(busy), 64'd0);

        // write, slot2 (rr=1 so slot2 is searched first)
        l1o[2].aw_valid     = 1'b1;
        l1o[2].aw_bits.addr = 32'h0000_1000;
        l1o[2].aw_user      = 2'd1;
        settle();
        chk("wr_aw_ready", 64'(l1i[2].aw_ready), 64'd1);
        chk("wr_no_ar_ready", 64'(ar_readys()), 64'd0);
        tick();
        l1o[2].aw_valid = 1'b0;
        l1o[2].aw_bits  = '0;
        l1o[2].w_valid  = 1'b1;
        l1o[2].w_data   = 64'h1122_3344_5566_7788;
        l1o[2].w_strb   = 8'hFF;
        l1o[2].w_last   = 1'b1;
        settle();
        chk("wr_grant", 64'(grant), 64'd2);
        chk("wr_l2_aw_valid", 64'(l2o.aw_valid), 64'd1);
        chk("wr_l2_aw_addr", 64'(l2o.aw_bits.addr), 64'h1000);
        chk("wr_l2_aw_id", 64'(l2o.aw_id), 64'd2);
        chk("wr_w_not_yet", 64'(l2o.w_valid), 64'd0);
        l2i.aw_ready = 1'b1;
        tick();
        l2i.aw_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("wr_w_stall_valid", 64'(l2o.w_valid), 64'd1);
            chk("wr_w_stall_data", l2o.w_data, 64'h1122_3344_5566_7788);
            chk("wr_w_stall_ready", 64'(l1i[2].w_ready), 64'd0);
            tick();
        end
        chk("wr_w_strb", 64'(l2o.w_strb), 64'hFF);
        l2i.w_ready = 1'b1;
        settle();
        chk("wr_w_ready", 64'(l1i[2].w_ready), 64'd1);
        tick();
        l2i.w_ready    = 1'b0;
        l1o[2].w_valid = 1'b0;
        l1o[2].w_last  = 1'b0;
        l2i.b_valid    = 1'b1;
        l2i.b_resp     = 2'b10;
        l2i.b_id       = 4'd2;
        l1o[2].b_ready = 1'b1;
        settle();
        chk("wr_no_dup_beat", 64'(l2o.w_valid), 64'd0);
        chk("wr_b_valid", 64'(l1i[2].b_valid), 64'd1);
        chk("wr_b_resp", 64'(l1i[2].b_resp), 64'h2);
        chk("wr_b_other", 64'({l1i[1].b_valid, l1i[0].b_valid}), 64'd0);
        chk("wr_l2_b_ready", 64'(l2o.b_ready), 64'd1);
        tick();
        l2i = '0;
        l1o = '0;
        settle();
        chk("wr_back_idle", 64'(busy), 64'd0);

        // round robin from rr=0 with three slots reading continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            l1o[s].ar_valid     = 1'b1;
            l1o[s].ar_bits.addr = 32'h100 * (s + 1);
            l1o[s].r_ready      = 1'b1;
        end
        for (int t = 0; t < 4; t++) begin
            settle();
            chk("rr_ar_ready", 64'(ar_readys()), 64'(1) << order[t]);
            tick();
            chk("rr_grant", 64'(grant), 64'(order[t]));
            chk("rr_no_ready_busy", 64'(ar_readys()), 64'd0);
            l2i.ar_ready = 1'b1;
            settle();
            chk("rr_ar_id", 64'(l2o.ar_id), 64'(order[t]));
            tick();
            l2i.ar_ready = 1'b0;
            l2i.r_valid  = 1'b1;
            l2i.r_last   = 1'b1;
            settle();
            chk("rr_r_to_winner", 64'(l1i[order[t]].r_valid), 64'd1);
            tick();
            l2i = '0;
        end
        l1o = '0;

        // reset mid-WaitR, slot0 (rr=1, search 2 then 0)
        l1o[0].ar_valid = 1'b1;
        settle();
        chk("rm_ar_ready", 64'(ar_readys()), 64'h1);
        tick();
        l1o[0].ar_valid = 1'b0;
        l2i.ar_ready    = 1'b1;
        tick();
        l2i.ar_ready   = 1'b0;
        l2i.r_valid    = 1'b1;
        l2i.r_last     = 1'b0;
        l1o[0].r_ready = 1'b1;
        settle();
        chk("rm_pre_r_ready", 64'(l2o.r_ready), 64'd1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rm_r_ready", 64'(l2o.r_ready), 64'd0);
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_grant", 64'(grant), 64'd0);
        chk("rm_l1i_none", 64'(l1i === '0), 64'd1);
        l2i = '0;
        l1o = '0;
        l1o[2].ar_valid = 1'b1;
        settle();
        chk("rm_next_ar_ready", 64'(ar_readys()), 64'h4);
        tick();
        l1o[2].ar_valid = 1'b0;
        chk("rm_next_grant", 64'(grant), 64'd2);
        l2i.ar_ready = 1'b1;
        tick();
        l2i.ar_ready   = 1'b0;
        l2i.r_valid    = 1'b1;
        l2i.r_last     = 1'b1;
        l1o[2].r_ready = 1'b1;
        tick();
        l2i = '0;
        l1o = '0;

        // R backpressure, slot1 (rr=2, search 0 then 1)
        l1o[1].ar_valid = 1'b1;
        tick();
        l1o[1].ar_valid = 1'b0;
        chk("bp_grant", 64'(grant), 64'd1);
        l2i.ar_ready = 1'b1;
        tick();
        l2i.ar_ready = 1'b0;
        l2i.r_valid  = 1'b1;
        l2i.r_last   = 1'b1;
        l2i.r_data   = 64'hDEAD_BEEF_0BAD_F00D;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("bp_l2_r_ready", 64'(l2o.r_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_r_data", l1i[1].r_data, 64'hDEAD_BEEF_0BAD_F00D);
            tick();
        end
        l1o[1].r_ready = 1'b1;
        settle();
        chk("bp_release", 64'(l2o.r_ready), 64'd1);
        tick();
        l2i = '0;
        l1o = '0;
        settle();
        chk("bp_idle", 64'(busy), 64'd0);

        // same slot ar+aw, read first (rr=1, search 2 then 0)
        l1o[0].ar_valid     = 1'b1;
        l1o[0].ar_bits.addr = 32'h0000_2000;
        l1o[0].aw_valid     = 1'b1;
        l1o[0].aw_bits.addr = 32'h0000_3000;
        settle();
        chk("pr_ar_ready", 64'(l1i[0].ar_ready), 64'd1);
        chk("pr_aw_ready", 64'(l1i[0].aw_ready), 64'd0);
        tick();
        l1o[0].ar_valid = 1'b0;
        settle();
        chk("pr_l2_ar", 64'(l2o.ar_valid), 64'd1);
        chk("pr_l2_aw", 64'(l2o.aw_valid), 64'd0);
        chk("pr_rd_addr", 64'(l2o.ar_bits.addr), 64'h2000);
        l2i.ar_ready = 1'b1;
        tick();
        l2i.ar_ready   = 1'b0;
        l2i.r_valid    = 1'b1;
        l2i.r_last     = 1'b1;
        l1o[0].r_ready = 1'b1;
        tick();
        l2i            = '0;
        l1o[0].r_ready = 1'b0;
        settle();
        chk("pr_aw_ready_later", 64'(l1i[0].aw_ready), 64'd1);
        tick();
        l1o[0].aw_valid = 1'b0;
        l1o[0].w_valid  = 1'b1;
        l1o[0].w_last   = 1'b1;
        settle();
        chk("pr_l2_aw_addr", 64'(l2o.aw_bits.addr), 64'h3000);
        l2i.aw_ready = 1'b1;
        tick();
        l2i.aw_ready = 1'b0;
        l2i.w_ready  = 1'b1;
        tick();
        l2i.w_ready    = 1'b0;
        l1o[0].w_valid = 1'b0;
        l2i.b_valid    = 1'b1;
        l1o[0].b_ready = 1'b1;
        settle();
        chk("pr_b_valid", 64'(l1i[0].b_valid), 64'd1);
        tick();
        l2i = '0;
        l1o = '0;
        settle();
        chk("pr_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
